// File: rtl/br_seq_pkg.sv
// ---------------------------------------------------------------------------
// br_seq_pkg
//  Shared definitions for the BR sequencer: register-file geometry, command
//  op encodings and FSM state codes. Imported by br_seq.
// ---------------------------------------------------------------------------
package br_seq_pkg;

   localparam int NUM_REGS = 32;
   localparam int REG_AW   = 5;

   // Highest register address; every sweep terminates here
   localparam logic [REG_AW-1:0] LAST_ADDR = REG_AW'(NUM_REGS - 1);

   typedef enum logic [1:0] {
      OP_CLEAR = 2'b00,
      OP_DUMP  = 2'b01,
      OP_WRITE = 2'b10,
      OP_READ  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CLR  = 3'd1,
      S_WR   = 3'd2,
      S_RD   = 3'd3,
      S_RSP  = 3'd4,
      S_FIN  = 3'd5,
      S_VFY  = 3'd6
   } state_e;

   // Step to the following register address. Callers always test for
   // LAST_ADDR first, so the 5-bit wrap is never exercised.
   function automatic logic [REG_AW-1:0] nextAddr(input logic [REG_AW-1:0] addr);
      return addr + REG_AW'(1);
   endfunction

endpackage

// File: rtl/br_seq.sv
// ---------------------------------------------------------------------------
// br_seq
//  Command initiator for the BR register file. Accepts CLEAR / DUMP / WRITE /
//  READ commands on a valid-ready stream and drives the BR ports (a1 read,
//  a2 verify read, a3/we/wd3 write). Read data is returned as beats on a
//  valid-ready response stream. All BR-facing outputs are registered so they
//  never depend combinationally on cmd_* or rsp_ready.
//
//  Optional feature macro: BR_SEQ_VERIFY_EN
//   defined   : every write is read back on a2 the following cycle and a
//               mismatch sets the sticky verify_err (cleared on next accept);
//               CLEAR and WRITE spend one extra cycle before completion.
//   undefined : br_a2 and verify_err are tied to zero.
//
//  Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   cmd_valid/ready        command handshake
//   cmd_op/addr/data       op (00 CLEAR, 01 DUMP, 10 WRITE, 11 READ), target, data
//   rsp_valid/ready        response beat handshake
//   rsp_addr/data/last     beat contents; last on addr 31 of DUMP and every READ
//   busy, done             busy from accept to done; done is a one-cycle pulse
//   verify_err             sticky read-back mismatch flag
//   br_we/a1/a2/a3/wd3     drive BR
//   br_rd1, br_rd2         BR combinational read data
// ---------------------------------------------------------------------------
module br_seq
   import br_seq_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] CLEAR_VALUE = '0,
   parameter int              CLEAR_FROM  = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [REG_AW-1:0] cmd_addr,
   input  logic [XLEN-1:0]   cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [REG_AW-1:0] rsp_addr,
   output logic [XLEN-1:0]   rsp_data,
   output logic              rsp_last,
   output logic              busy,
   output logic              done,
   output logic              verify_err,
   output logic              br_we,
   output logic [REG_AW-1:0] br_a1,
   output logic [REG_AW-1:0] br_a2,
   output logic [REG_AW-1:0] br_a3,
   output logic [XLEN-1:0]   br_wd3,
   input  logic [XLEN-1:0]   br_rd1,
   input  logic [XLEN-1:0]   br_rd2
);

   localparam logic [REG_AW-1:0] CLR_START = REG_AW'(CLEAR_FROM);

   // Where a write sequence goes once its last write has been issued: through
   // the read-back cycle when verification is built in, otherwise straight on.
`ifdef BR_SEQ_VERIFY_EN
   localparam state_e POST_WRITE = S_VFY;
`else
   localparam state_e POST_WRITE = S_FIN;
`endif

   state_e            state_q;
   op_e               op_q;
   logic [REG_AW-1:0] ptr_q;
   logic              cmdReady_q;
   logic              rspValid_q;
   logic [REG_AW-1:0] rspAddr_q;
   logic [XLEN-1:0]   rspData_q;
   logic              rspLast_q;
   logic              busy_q;
   logic              done_q;
   logic              brWe_q;
   logic [REG_AW-1:0] brA1_q;
   logic [REG_AW-1:0] brA3_q;
   logic [XLEN-1:0]   brWd3_q;

`ifdef BR_SEQ_VERIFY_EN
   logic              vfyPend_q;
   logic [REG_AW-1:0] brA2_q;
   logic [XLEN-1:0]   vfyData_q;
   logic              verifyErr_q;
`else
   logic [XLEN-1:0]   unusedRd2;
   assign unusedRd2 = br_rd2;
`endif

   // Sequencer FSM. Every output is a register updated here so the BR ports
   // and the response stream change only on clock edges (or on reset, which
   // drops br_we and any pending beat immediately). The write-verify pipeline
   // shares this block because its error flag is cleared by command accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         op_q        <= OP_CLEAR;
         ptr_q       <= '0;
         cmdReady_q  <= 1'b1;
         rspValid_q  <= 1'b0;
         rspAddr_q   <= '0;
         rspData_q   <= '0;
         rspLast_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         brWe_q      <= 1'b0;
         brA1_q      <= '0;
         brA3_q      <= '0;
         brWd3_q     <= '0;
`ifdef BR_SEQ_VERIFY_EN
         vfyPend_q   <= 1'b0;
         brA2_q      <= '0;
         vfyData_q   <= '0;
         verifyErr_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  cmdReady_q <= 1'b0;
                  busy_q     <= 1'b1;
                  op_q       <= op_e'(cmd_op);
`ifdef BR_SEQ_VERIFY_EN
                  verifyErr_q <= 1'b0;
`endif
                  case (op_e'(cmd_op))
                     OP_CLEAR: begin
                        ptr_q   <= CLR_START;
                        brWe_q  <= 1'b1;
                        brA3_q  <= CLR_START;
                        brWd3_q <= CLEAR_VALUE;
                        state_q <= S_CLR;
                     end
                     OP_WRITE: begin
                        brWe_q  <= 1'b1;
                        brA3_q  <= cmd_addr;
                        brWd3_q <= cmd_data;
                        state_q <= S_WR;
                     end
                     OP_DUMP: begin
                        ptr_q   <= '0;
                        brA1_q  <= '0;
                        state_q <= S_RD;
                     end
                     OP_READ: begin
                        ptr_q   <= cmd_addr;
                        brA1_q  <= cmd_addr;
                        state_q <= S_RD;
                     end
                  endcase
               end
            end

            // One write per cycle; the terminal compare comes before the
            // increment so the pointer never wraps past 31.
            S_CLR: begin
               if (ptr_q == LAST_ADDR) begin
                  brWe_q  <= 1'b0;
                  done_q  <= (POST_WRITE == S_FIN);
                  state_q <= POST_WRITE;
               end else begin
                  ptr_q  <= nextAddr(ptr_q);
                  brA3_q <= nextAddr(ptr_q);
               end
            end

            S_WR: begin
               brWe_q  <= 1'b0;
               done_q  <= (POST_WRITE == S_FIN);
               state_q <= POST_WRITE;
            end

            // Read-back of the final write happens during this cycle.
            S_VFY: begin
               done_q  <= 1'b1;
               state_q <= S_FIN;
            end

            // br_a1 has been pointing at ptr for this whole cycle, so BR's
            // combinational read data is settled and can be captured.
            S_RD: begin
               rspData_q  <= br_rd1;
               rspAddr_q  <= ptr_q;
               rspValid_q <= 1'b1;
               rspLast_q  <= (op_q == OP_READ) || (ptr_q == LAST_ADDR);
               state_q    <= S_RSP;
            end

            // Beat stays frozen until the consumer takes it.
            S_RSP: begin
               if (rsp_ready) begin
                  rspValid_q <= 1'b0;
                  if ((op_q == OP_DUMP) && (ptr_q != LAST_ADDR)) begin
                     ptr_q   <= nextAddr(ptr_q);
                     brA1_q  <= nextAddr(ptr_q);
                     state_q <= S_RD;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= S_FIN;
                  end
               end
            end

            S_FIN: begin
               busy_q     <= 1'b0;
               cmdReady_q <= 1'b1;
               state_q    <= S_IDLE;
            end

            default: begin
               brWe_q     <= 1'b0;
               rspValid_q <= 1'b0;
               busy_q     <= 1'b0;
               cmdReady_q <= 1'b1;
               state_q    <= S_IDLE;
            end
         endcase

`ifdef BR_SEQ_VERIFY_EN
         // A write issued this cycle is read back on a2 next cycle; BR holds
         // the new value by then, so any difference is a write failure.
         vfyPend_q <= brWe_q;
         if (brWe_q) begin
            brA2_q    <= brA3_q;
            vfyData_q <= brWd3_q;
         end
         if (vfyPend_q && (br_rd2 != vfyData_q)) begin
            verifyErr_q <= 1'b1;
         end
`endif
      end
   end

   assign cmd_ready = cmdReady_q;
   assign rsp_valid = rspValid_q;
   assign rsp_addr  = rspAddr_q;
   assign rsp_data  = rspData_q;
   assign rsp_last  = rspLast_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign br_we     = brWe_q;
   assign br_a1     = brA1_q;
   assign br_a3     = brA3_q;
   assign br_wd3    = brWd3_q;

`ifdef BR_SEQ_VERIFY_EN
   assign br_a2      = brA2_q;
   assign verify_err = verifyErr_q;
`else
   assign br_a2      = '0;
   assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_br_seq.sv
// ---------------------------------------------------------------------------
// tb_br_seq
//  Testbench for br_seq with a behavioural BR register file attached. A plain
//  array holds what each BR register should contain; every read beat and
//  write strobe is compared against it. With BR_SEQ_VERIFY_EN defined the BR
//  model corrupts writes to register 10 to provoke verify_err.
// ---------------------------------------------------------------------------
module tb_br_seq;

   localparam int XLEN = 32;

   localparam logic [1:0] OP_CLR_C = 2'b00;
   localparam logic [1:0] OP_DMP_C = 2'b01;
   localparam logic [1:0] OP_WR_C  = 2'b10;
   localparam logic [1:0] OP_RD_C  = 2'b11;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            cmd_valid;
   logic            cmd_ready;
   logic [1:0]      cmd_op;
   logic [4:0]      cmd_addr;
   logic [XLEN-1:0] cmd_data;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [4:0]      rsp_addr;
   logic [XLEN-1:0] rsp_data;
   logic            rsp_last;
   logic            busy;
   logic            done;
   logic            verify_err;
   logic            br_we;
   logic [4:0]      br_a1;
   logic [4:0]      br_a2;
   logic [4:0]      br_a3;
   logic [XLEN-1:0] br_wd3;
   logic [XLEN-1:0] br_rd1;
   logic [XLEN-1:0] br_rd2;

   logic [XLEN-1:0] brMem [32];
   logic [XLEN-1:0] model [32];

   int nCompared   = 0;
   int nMismatched = 0;

   // What BR ends up storing for a write; register 10 is faulty when the
   // verify feature is under test.
   function automatic logic [XLEN-1:0] brStored(input logic [4:0] a, input logic [XLEN-1:0] d);
`ifdef BR_SEQ_VERIFY_EN
      if (a == 5'd10) return d ^ 32'h1;
`endif
      return d;
   endfunction

   always #5 clk = ~clk;

   // Behavioural BR: synchronous write, combinational reads.
   always @(posedge clk) begin
      if (br_we) brMem[br_a3] <= brStored(br_a3, br_wd3);
   end
   assign br_rd1 = brMem[br_a1];
   assign br_rd2 = brMem[br_a2];

   br_seq #(.XLEN(XLEN), .CLEAR_VALUE('0), .CLEAR_FROM(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
      .rsp_data(rsp_data), .rsp_last(rsp_last),
      .busy(busy), .done(done), .verify_err(verify_err),
      .br_we(br_we), .br_a1(br_a1), .br_a2(br_a2), .br_a3(br_a3),
      .br_wd3(br_wd3), .br_rd1(br_rd1), .br_rd2(br_rd2)
   );

   // Offer a command at a falling edge and hold it until accepted; returns
   // at the falling edge right after the accepting rising edge.
   task automatic applyStimulus(input logic [1:0] op, input logic [4:0] addr, input logic [XLEN-1:0] data);
      int guard;
      cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
      guard = 0;
      while (!cmd_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!cmd_ready) begin
         nCompared++; nMismatched++;
         $display("[TB] FAIL accept_timeout: cmd_ready=%0b required 1", cmd_ready);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic waitDone(input string tag);
      int guard;
      guard = 0;
      while (!done && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (!done) begin
         nCompared++; nMismatched++;
         $display("[TB] FAIL %s_done_timeout: done=%0b required 1", tag, done);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_op = '0; cmd_addr = '0; cmd_data = '0;
      repeat (2) @(negedge clk);
      nCompared++;
      if ({cmd_ready, rsp_valid, rsp_last, busy, done, verify_err, br_we} !== 7'b1000000) begin
         nMismatched++;
         $display("[TB] FAIL reset_flags: got %b required 1000000",
                  {cmd_ready, rsp_valid, rsp_last, busy, done, verify_err, br_we});
      end
      nCompared++;
      if ({rsp_addr, br_a1, br_a2, br_a3} !== 20'h0) begin
         nMismatched++;
         $display("[TB] FAIL reset_addrs: got %h required 0", {rsp_addr, br_a1, br_a2, br_a3});
      end
      nCompared++;
      if ({rsp_data, br_wd3} !== 64'h0) begin
         nMismatched++;
         $display("[TB] FAIL reset_data: got %h required 0", {rsp_data, br_wd3});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_clear();
      applyStimulus(OP_CLR_C, 5'd0, '0);
      nCompared++;
      if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL clear_busy: busy=%0b cmd_ready=%0b required 1/0", busy, cmd_ready);
      end
      for (int i = 0; i < 32; i++) begin
         nCompared++;
         if (br_we !== 1'b1 || br_a3 !== 5'(i) || br_wd3 !== '0) begin
            nMismatched++;
            $display("[TB] FAIL clear_write[%0d]: we=%0b a3=%0d wd3=%h required 1/%0d/0",
                     i, br_we, br_a3, br_wd3, i);
         end
         @(negedge clk);
      end
`ifdef BR_SEQ_VERIFY_EN
      nCompared++;
      if (done !== 1'b0 || br_we !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL clear_verify_gap: done=%0b we=%0b required 0/0", done, br_we);
      end
      @(negedge clk);
`endif
      nCompared++;
      if (done !== 1'b1 || br_we !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL clear_done: done=%0b we=%0b required 1/0", done, br_we);
      end
      @(negedge clk);
      nCompared++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL clear_idle: busy=%0b ready=%0b done=%0b required 0/1/0", busy, cmd_ready, done);
      end
      for (int i = 0; i < 32; i++) model[i] = brStored(5'(i), '0);
`ifndef BR_SEQ_VERIFY_EN
      nCompared++;
      if (verify_err !== 1'b0 || br_a2 !== 5'd0) begin
         nMismatched++;
         $display("[TB] FAIL verify_tied: verify_err=%0b a2=%0d required 0/0", verify_err, br_a2);
      end
`endif
   endtask

   // mode 0: always ready, 1: ready toggles every cycle, 2: random ready
   task automatic test_dump(input int mode, input string tag);
      int idx, guard;
      bit sawDone, prevStall, tog;
      logic [4:0] pa;
      logic [XLEN-1:0] pd;
      logic pl;
      idx = 0; guard = 0; sawDone = 0; prevStall = 0; tog = 0;
      pa = '0; pd = '0; pl = 1'b0;
      rsp_ready = 1'b0;
      applyStimulus(OP_DMP_C, 5'd0, '0);
      while (!sawDone && guard < 400) begin
         if (done) sawDone = 1;
         if (rsp_valid) begin
            nCompared++;
            if (idx >= 32) begin
               nMismatched++;
               $display("[TB] FAIL %s_extra_beat: addr=%0d beyond 32 beats", tag, rsp_addr);
            end else if (prevStall) begin
               if ({rsp_addr, rsp_data, rsp_last} !== {pa, pd, pl}) begin
                  nMismatched++;
                  $display("[TB] FAIL %s_stall_stable: got %0d/%h/%0b required %0d/%h/%0b",
                           tag, rsp_addr, rsp_data, rsp_last, pa, pd, pl);
               end
            end else begin
               if (rsp_addr !== 5'(idx) || rsp_data !== model[idx] || rsp_last !== (idx == 31)) begin
                  nMismatched++;
                  $display("[TB] FAIL %s_beat[%0d]: got %0d/%h/%0b required %0d/%h/%0b",
                           tag, idx, rsp_addr, rsp_data, rsp_last, idx, model[idx], (idx == 31));
               end
            end
         end
         case (mode)
            0: rsp_ready = 1'b1;
            1: begin tog = !tog; rsp_ready = tog; end
            default: rsp_ready = 1'($urandom_range(0, 1));
         endcase
         if (rsp_valid && rsp_ready) begin
            idx++;
            prevStall = 0;
         end else if (rsp_valid) begin
            prevStall = 1;
            pa = rsp_addr; pd = rsp_data; pl = rsp_last;
         end
         @(negedge clk);
         guard++;
      end
      rsp_ready = 1'b0;
      nCompared++;
      if (!sawDone || idx != 32) begin
         nMismatched++;
         $display("[TB] FAIL %s_count: beats=%0d done=%0b required 32/1", tag, idx, sawDone);
      end
   endtask

   task automatic test_write(input logic [4:0] addr, input logic [XLEN-1:0] data);
      applyStimulus(OP_WR_C, addr, data);
      nCompared++;
      if (br_we !== 1'b1 || br_a3 !== addr || br_wd3 !== data) begin
         nMismatched++;
         $display("[TB] FAIL write_strobe: we=%0b a3=%0d wd3=%h required 1/%0d/%h", br_we, br_a3, br_wd3, addr, data);
      end
      @(negedge clk);
`ifdef BR_SEQ_VERIFY_EN
      nCompared++;
      if (done !== 1'b0 || br_we !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL write_verify_gap: done=%0b we=%0b required 0/0", done, br_we);
      end
      @(negedge clk);
`endif
      nCompared++;
      if (done !== 1'b1 || br_we !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL write_done: done=%0b we=%0b required 1/0", done, br_we);
      end
      @(negedge clk);
      model[addr] = brStored(addr, data);
   endtask

   task automatic test_read(input logic [4:0] addr, input int stall);
      applyStimulus(OP_RD_C, addr, '0);
      nCompared++;
      if (rsp_valid !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL read_early: rsp_valid=%0b required 0", rsp_valid);
      end
      @(negedge clk);
      nCompared++;
      if (rsp_valid !== 1'b1 || rsp_addr !== addr || rsp_data !== model[addr] || rsp_last !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL read_beat: got %0b/%0d/%h/%0b required 1/%0d/%h/1",
                  rsp_valid, rsp_addr, rsp_data, rsp_last, addr, model[addr]);
      end
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         nCompared++;
         if (rsp_valid !== 1'b1 || rsp_addr !== addr || rsp_data !== model[addr]) begin
            nMismatched++;
            $display("[TB] FAIL read_hold: got %0b/%0d/%h required 1/%0d/%h",
                     rsp_valid, rsp_addr, rsp_data, addr, model[addr]);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      nCompared++;
      if (rsp_valid !== 1'b0 || done !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL read_done: valid=%0b done=%0b required 0/1", rsp_valid, done);
      end
      @(negedge clk);
   endtask

   task automatic test_preload_dump();
      for (int i = 0; i < 32; i++) test_write(5'(i), XLEN'(i));
      test_dump(1, "dump_toggle");
   endtask

   task automatic test_random();
      logic [4:0] a;
      for (int n = 0; n < 24; n++) begin
         a = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 1) == 0) test_write(a, $urandom);
         else test_read(a, int'($urandom_range(0, 3)));
      end
      test_dump(2, "dump_random");
   endtask

   task automatic test_back_to_back();
      int guard, accepts, weCount, beats;
      bit sawDone;
      guard = 0; accepts = 0; weCount = 0; beats = 0; sawDone = 0;
      applyStimulus(OP_DMP_C, 5'd0, '0);
      cmd_op = OP_WR_C; cmd_addr = 5'd7; cmd_data = 32'hABCD_1234; cmd_valid = 1'b1;
      rsp_ready = 1'b1;
      while (!sawDone && guard < 400) begin
         if (done) sawDone = 1;
         nCompared++;
         if (cmd_ready !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL b2b_ready_busy: cmd_ready=%0b required 0 at cycle %0d", cmd_ready, guard);
         end
         if (rsp_valid) beats++;
         if (br_we && br_a3 == 5'd7) weCount++;
         @(negedge clk);
         guard++;
      end
      rsp_ready = 1'b0;
      nCompared++;
      if (cmd_ready !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL b2b_ready_after: cmd_ready=%0b required 1", cmd_ready);
      end
      for (int c = 0; c < 12; c++) begin
         if (br_we && br_a3 == 5'd7) weCount++;
         if (cmd_valid && cmd_ready) begin
            accepts++;
            @(negedge clk);
            cmd_valid = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      cmd_valid = 1'b0;
      nCompared++;
      if (accepts != 1 || weCount != 1 || beats != 32) begin
         nMismatched++;
         $display("[TB] FAIL b2b_once: accepts=%0d writes=%0d beats=%0d required 1/1/32", accepts, weCount, beats);
      end
      model[7] = brStored(5'd7, 32'hABCD_1234);
      test_read(5'd7, 1);
   endtask

   task automatic test_reset_mid();
      int guard;
      guard = 0;
      applyStimulus(OP_DMP_C, 5'd0, '0);
      rsp_ready = 1'b1;
      while (!(rsp_valid && rsp_addr == 5'd10) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      nCompared++;
      if (!(rsp_valid && rsp_addr == 5'd10)) begin
         nMismatched++;
         $display("[TB] FAIL rstmid_beat10: valid=%0b addr=%0d required 1/10", rsp_valid, rsp_addr);
      end
      rsp_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      nCompared++;
      if (rsp_valid !== 1'b0 || br_we !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL rstmid_dump_abort: valid=%0b we=%0b required 0/0", rsp_valid, br_we);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      nCompared++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL rstmid_idle: ready=%0b busy=%0b valid=%0b required 1/0/0", cmd_ready, busy, rsp_valid);
      end
      applyStimulus(OP_CLR_C, 5'd0, '0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      nCompared++;
      if (br_we !== 1'b0 || busy !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL rstmid_clear_abort: we=%0b busy=%0b required 0/0", br_we, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_clear();
   endtask

`ifdef BR_SEQ_VERIFY_EN
   task automatic test_verify();
      applyStimulus(OP_CLR_C, 5'd0, '0);
      waitDone("verify_clear");
      for (int i = 0; i < 32; i++) model[i] = brStored(5'(i), '0);
      nCompared++;
      if (verify_err !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL verify_set: verify_err=%0b required 1", verify_err);
      end
      repeat (3) @(negedge clk);
      nCompared++;
      if (verify_err !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL verify_sticky: verify_err=%0b required 1", verify_err);
      end
      applyStimulus(OP_WR_C, 5'd3, 32'd77);
      nCompared++;
      if (verify_err !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL verify_clear_on_accept: verify_err=%0b required 0", verify_err);
      end
      waitDone("verify_wr3");
      model[3] = 32'd77;
      nCompared++;
      if (verify_err !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL verify_clean_write: verify_err=%0b required 0", verify_err);
      end
      applyStimulus(OP_WR_C, 5'd10, 32'h55);
      waitDone("verify_wr10");
      model[10] = brStored(5'd10, 32'h55);
      nCompared++;
      if (verify_err !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL verify_bad_write: verify_err=%0b required 1", verify_err);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_clear();
      test_dump(0, "dump_zero");
      test_write(5'd5, 32'd42);
      test_read(5'd5, 0);
      test_preload_dump();
      test_random();
      test_back_to_back();
      test_reset_mid();
`ifdef BR_SEQ_VERIFY_EN
      test_verify();
`endif
      test_dump(2, "dump_final");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
